glb_write_pack: RTL

Synthesizable stream packer between the fabric output stream and the GLB readback port. It buffers one block of 17-bit ready/valid words, counts them, and then emits a length-prefixed block: one header word holding the count, followed by the buffered words in arrival order. Its output is the format the GLB read-side sink consumes, for NUM_BLOCKS consecutive blocks per run.

---
 rtl/glb_write_pack_pkg.sv | 16 +
 rtl/glb_write_pack_buf.sv | 24 ++
 rtl/glb_write_pack.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/glb_write_pack_pkg.sv
// Shared types and widths for the GLB write-side block packer.
package glb_write_pack_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned WORD_W    = DATA_W + 1;
  localparam int unsigned TOKEN_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    HDR,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/glb_write_pack_buf.sv
// Block buffer: simple dual-port RAM, one write port, one synchronous-read port, no content reset.
module glb_write_pack_buf
  import glb_write_pack_pkg::*;
#(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [AW-1:0]     ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/glb_write_pack.sv
// Stream packer: buffers one ready/valid block, then emits a count header followed by the
// buffered words, for NUM_BLOCKS blocks per run.
module glb_write_pack
  import glb_write_pack_pkg::*;
#(
  parameter int unsigned DEPTH      = 2048,
  parameter int unsigned NUM_BLOCKS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BLK_W = 2;

  if (DEPTH > 65535) begin : g_bad_depth
    $error("glb_write_pack: DEPTH must not exceed 65535");
  end
  if (NUM_BLOCKS < 1 || NUM_BLOCKS > 2) begin : g_bad_blocks
    $error("glb_write_pack: NUM_BLOCKS must be 1 or 2");
  end

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CNT_W-1:0]    rd_addr, rd_addr_n;
  logic [BLK_W-1:0]    blk_cnt, blk_n;
  logic                rd_pend, flush_q;
  logic                skid_valid, skid_valid_n, out_valid_n;
  logic [WORD_W-1:0]   skid_data, skid_data_n, out_data_n;
  logic                we, rd_en, hdr_push, blk_end;
  logic                in_fire, pop, push_v;
  logic [WORD_W-1:0]   push_d, hdr_word;
  logic [2:0]          occ_after;
  logic [DATA_W-1:0]   rd_data;

  assign in_fire = in_valid && in_ready;
  assign pop     = out_valid && out_ready;
  // Occupancy of the output pair once this cycle's pop and in-flight read settle.
  assign occ_after = 3'(out_valid) + 3'(skid_valid) + 3'(rd_pend) - 3'(pop);

  glb_write_pack_buf #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_buf (
    .clk(clk),
    .we (we),
    .wa (AW'(cnt)),
    .wd (in_data[DATA_W-1:0]),
    .re (rd_en),
    .ra (AW'(rd_addr)),
    .rd (rd_data)
  );

  // Next-state, counters and read prefetch.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    blk_n     = blk_cnt;
    rd_addr_n = rd_addr;
    we        = 1'b0;
    hdr_push  = 1'b0;
    blk_end   = 1'b0;
    rd_en     = !flush && (state == HDR || state == DRAIN) && (rd_addr < cnt) && (occ_after < 3'd2);
    if (rd_en) rd_addr_n = rd_addr + CNT_W'(1);

    unique case (state)
      IDLE: begin
        if (flush_q) begin
          state_n   = FILL;
          cnt_n     = '0;
          rd_addr_n = '0;
        end
      end
      FILL: begin
        if (in_fire) begin
          if (in_data[TOKEN_BIT]) begin
            state_n  = HDR;
            hdr_push = 1'b1;
          end else begin
            we    = 1'b1;
            cnt_n = cnt + CNT_W'(1);
            if (cnt == CNT_W'(DEPTH - 1)) begin
              state_n  = HDR;
              hdr_push = 1'b1;
            end
          end
        end
      end
      HDR: begin
        if (pop) begin
          if (cnt == '0) blk_end = 1'b1;
          else           state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && !skid_valid && !rd_pend && (rd_addr == cnt)) blk_end = 1'b1;
      end
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase

    if (blk_end) begin
      blk_n     = blk_cnt + BLK_W'(1);
      cnt_n     = '0;
      rd_addr_n = '0;
      state_n   = (blk_n == BLK_W'(NUM_BLOCKS)) ? DONE : FILL;
    end

    if (flush) begin
      state_n   = IDLE;
      cnt_n     = '0;
      blk_n     = '0;
      rd_addr_n = '0;
      we        = 1'b0;
      hdr_push  = 1'b0;
    end
  end

  // Two-entry output queue: out_* is the head, skid_* absorbs the RAM read latency.
  always_comb begin
    hdr_word     = {1'b0, DATA_W'(cnt_n)};
    push_v       = hdr_push || rd_pend;
    push_d       = hdr_push ? hdr_word : {1'b0, rd_data};
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;

    if (pop) begin
      if (skid_valid) begin
        out_data_n   = skid_data;
        skid_valid_n = push_v;
        skid_data_n  = push_d;
      end else begin
        out_valid_n = push_v;
        if (push_v) out_data_n = push_d;
      end
    end else if (push_v) begin
      if (!out_valid) begin
        out_valid_n = 1'b1;
        out_data_n  = push_d;
      end else begin
        skid_valid_n = 1'b1;
        skid_data_n  = push_d;
      end
    end

    if (flush) begin
      out_valid_n  = 1'b0;
      skid_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      blk_cnt    <= '0;
      rd_addr    <= '0;
      rd_pend    <= 1'b0;
      flush_q    <= 1'b0;
      in_ready   <= 1'b0;
      done       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      blk_cnt    <= blk_n;
      rd_addr    <= rd_addr_n;
      rd_pend    <= rd_en;
      flush_q    <= flush;
      in_ready   <= (state_n == FILL);
      done       <= (state_n == DONE);
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
    end
  end

endmodule
